// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared encodings and defaults for the mult/div sequencer.
package muldiv_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_WRITE = 3'd3,
        S_DZ    = 3'd4
    } state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int ITER_DEF  = 32;
    localparam int CNT_W_DEF = 6;

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequences one MULT/DIV through the iterative units and commits HI/LO.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int ITER  = ITER_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             b_zero,
    input  logic             hilo_read,
    input  logic             flush,
    output logic             mult_start,
    output logic             div_start,
    output logic             mult_step,
    output logic             div_step,
    output logic             HiLo_load,
    output logic             sel_mux_hi,
    output logic             sel_mux_lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             stall,
    output logic [CNT_W-1:0] iter_count
);

    state_e             state_q, state_d;
    logic               op_q, op_d;
    logic               sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last;

    assign last = cnt_q == CNT_W'(ITER - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_MULT;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // sel is its own register so it reads 0 out of reset yet tracks ~op_r from LOAD on
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_DIV && b_zero) begin
                        state_d = S_DZ;
                    end else begin
                        state_d = S_LOAD;
                        op_d    = op;
                        sel_d   = ~op;
                    end
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d   = last ? cnt_q : cnt_q + 1'b1;
                state_d = last ? S_WRITE : S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            op_d    = op_q;
            sel_d   = sel_q;
        end
    end

    assign mult_start = state_q == S_LOAD && op_q == OP_MULT;
    assign div_start  = state_q == S_LOAD && op_q == OP_DIV;
    assign mult_step  = state_q == S_RUN && op_q == OP_MULT;
    assign div_step   = state_q == S_RUN && op_q == OP_DIV;
    assign HiLo_load  = state_q == S_WRITE && !flush;
    assign done       = state_q == S_WRITE && !flush;
    assign div_zero   = state_q == S_DZ && !flush;
    assign sel_mux_hi = sel_q;
    assign sel_mux_lo = sel_q;
    assign busy       = state_q != S_IDLE;
    assign stall      = hilo_read & busy;
    assign iter_count = cnt_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table-driven per-cycle check of the mult/div sequencer.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    localparam int NC = 64;
    localparam int NV = 11;

    typedef struct {
        bit          op;
        bit          bz;
        int          fl;
        int          s2;
        bit          s2op;
        int          rd_hi;
        logic [63:0] ms, ds, mst, dst, hl, dn, dz, busy, stall;
        bit          sel;
    } vec_t;

    logic clk, reset, start, op, b_zero, hilo_read, flush;
    logic mult_start, div_start, mult_step, div_step, HiLo_load;
    logic sel_mux_hi, sel_mux_lo, busy, done, div_zero, stall;
    logic [CNT_W_DEF-1:0] iter_count;

    logic [63:0] ms_v, ds_v, mst_v, dst_v, hl_v, dn_v, dz_v, busy_v, stall_v, shi_v, slo_v;
    int ic [NC];
    int n_chk, n_fail;
    vec_t vt [NV];

    muldiv_seq #(.ITER(ITER_DEF), .CNT_W(CNT_W_DEF)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .b_zero(b_zero),
        .hilo_read(hilo_read), .flush(flush),
        .mult_start(mult_start), .div_start(div_start),
        .mult_step(mult_step), .div_step(div_step),
        .HiLo_load(HiLo_load), .sel_mux_hi(sel_mux_hi), .sel_mux_lo(sel_mux_lo),
        .busy(busy), .done(done), .div_zero(div_zero), .stall(stall),
        .iter_count(iter_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic vec_t mk(input bit o, input bit z, input int fl, input int s2, input bit s2op,
                                input int rd_hi, input logic [63:0] ms, input logic [63:0] ds,
                                input logic [63:0] mst, input logic [63:0] dst, input logic [63:0] hl,
                                input logic [63:0] dn, input logic [63:0] dz, input logic [63:0] bsy,
                                input logic [63:0] stl, input bit sel);
        vec_t v;
        v.op = o; v.bz = z; v.fl = fl; v.s2 = s2; v.s2op = s2op; v.rd_hi = rd_hi;
        v.ms = ms; v.ds = ds; v.mst = mst; v.dst = dst; v.hl = hl; v.dn = dn;
        v.dz = dz; v.busy = bsy; v.stall = stl; v.sel = sel;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({mult_start, div_start, mult_step, div_step, HiLo_load, sel_mux_hi,
                    sel_mux_lo, busy, done, div_zero, stall, iter_count});
    endfunction

    task automatic run_vec(input vec_t v);
        {ms_v, ds_v, mst_v, dst_v, hl_v, dn_v, dz_v, busy_v, stall_v, shi_v, slo_v} = '0;
        for (int c = 0; c < NC; c++) begin
            start     = (c == 0) || (v.s2 >= 0 && c == v.s2);
            op        = (c == 0) ? v.op : v.s2op;
            b_zero    = (c == 0) ? v.bz : 1'b0;
            flush     = (c == v.fl);
            hilo_read = (c <= v.rd_hi);
            @(negedge clk);
            ms_v[c] = mult_start; ds_v[c] = div_start; mst_v[c] = mult_step; dst_v[c] = div_step;
            hl_v[c] = HiLo_load; dn_v[c] = done; dz_v[c] = div_zero; busy_v[c] = busy;
            stall_v[c] = stall; shi_v[c] = sel_mux_hi; slo_v[c] = sel_mux_lo;
            ic[c] = int'(iter_count);
            @(posedge clk); #1;
        end
        {start, op, b_zero, flush, hilo_read} = '0;
    endtask

    initial begin
        int mx, cnt_hl, cnt_busy;
        n_chk = 0; n_fail = 0;
        vt[0]  = mk(0, 0, -1, -1, 0, -1, rng(1,1), 0, rng(2,33), 0, rng(34,34), rng(34,34), 0, rng(1,34), 0, 1);
        vt[1]  = mk(1, 0, -1, -1, 0, -1, 0, rng(1,1), 0, rng(2,33), rng(34,34), rng(34,34), 0, rng(1,34), 0, 0);
        vt[2]  = mk(1, 1, -1, -1, 0, -1, 0, 0, 0, 0, 0, 0, rng(1,1), rng(1,1), 0, 0);
        vt[3]  = mk(0, 1, -1, -1, 0, -1, rng(1,1), 0, rng(2,33), 0, rng(34,34), rng(34,34), 0, rng(1,34), 0, 1);
        vt[4]  = mk(1, 1, 1, -1, 0, -1, 0, 0, 0, 0, 0, 0, 0, rng(1,1), 0, 1);
        vt[5]  = mk(1, 0, 0, -1, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[6]  = mk(1, 0, -1, 10, 0, -1, 0, rng(1,1), 0, rng(2,33), rng(34,34), rng(34,34), 0, rng(1,34), 0, 0);
        vt[7]  = mk(0, 0, 20, 21, 0, -1, rng(1,1) | rng(22,22), 0, rng(2,20) | rng(23,54), 0,
                    rng(55,55), rng(55,55), 0, rng(1,20) | rng(22,55), 0, 1);
        vt[8]  = mk(0, 0, 34, -1, 0, -1, rng(1,1), 0, rng(2,33), 0, 0, 0, 0, rng(1,34), 0, 1);
        vt[9]  = mk(0, 0, -1, -1, 0, 40, rng(1,1), 0, rng(2,33), 0, rng(34,34), rng(34,34), 0, rng(1,34), rng(1,34), 1);
        vt[10] = mk(1, 0, 1, -1, 0, -1, 0, rng(1,1), 0, 0, 0, 0, 0, rng(1,1), 0, 0);

        reset = 1'b0;
        {start, op, b_zero, flush} = '0;
        hilo_read = 1'b1;
        #12;
        chk("reset_outputs", outs(), 64'd0);
        hilo_read = 1'b0;
        #1 reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            run_vec(vt[i]);
            chk($sformatf("v%0d mult_start", i), ms_v, vt[i].ms);
            chk($sformatf("v%0d div_start", i), ds_v, vt[i].ds);
            chk($sformatf("v%0d mult_step", i), mst_v, vt[i].mst);
            chk($sformatf("v%0d div_step", i), dst_v, vt[i].dst);
            chk($sformatf("v%0d HiLo_load", i), hl_v, vt[i].hl);
            chk($sformatf("v%0d done", i), dn_v, vt[i].dn);
            chk($sformatf("v%0d div_zero", i), dz_v, vt[i].dz);
            chk($sformatf("v%0d busy", i), busy_v, vt[i].busy);
            chk($sformatf("v%0d stall", i), stall_v, vt[i].stall);
            chk($sformatf("v%0d sel_hi_end", i), 64'(shi_v[NC-1]), 64'(vt[i].sel));
            chk($sformatf("v%0d sel_lo_end", i), 64'(slo_v[NC-1]), 64'(vt[i].sel));
            mx = 0;
            for (int c = 0; c < NC; c++) mx = (ic[c] > mx) ? ic[c] : mx;
            chk($sformatf("v%0d iter_max_ok", i), 64'(mx <= ITER_DEF - 1), 64'd1);
        end

        run_vec(vt[0]);
        chk("iter_cnt_first_run", 64'(ic[2]), 64'd0);
        chk("iter_cnt_last_run", 64'(ic[33]), 64'(ITER_DEF - 1));
        chk("iter_cnt_write", 64'(ic[34]), 64'(ITER_DEF - 1));
        chk("sel_hi_at_write", 64'(shi_v[34]), 64'd1);

        for (int c = 0; c <= 15; c++) begin
            start = (c == 0);
            op    = 1'b1;
            if (c < 15) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        hilo_read = 1'b1;
        #1;
        chk("busy_before_areset", 64'(busy), 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("areset_outputs", outs(), 64'd0);
        #3 reset = 1'b1;
        hilo_read = 1'b0;
        cnt_hl = 0; cnt_busy = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            cnt_hl += int'(HiLo_load);
            cnt_busy += int'(busy);
        end
        chk("areset_no_hiload", 64'(cnt_hl), 64'd0);
        chk("areset_idle", 64'(cnt_busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
